// File: rtl/sodor_scratchpad_mem_if.sv
// Request/response bundle between the Sodor-2 core memory ports and the scratchpad.
// Port 0 is fetch (read-only), port 1 is data, dbg is the debug port.
interface sodor_scratchpad_mem_if;
    logic        p0_req_valid;
    logic [31:0] p0_req_bits_addr;
    logic        p0_req_bits_fcn;
    logic [2:0]  p0_req_bits_typ;
    logic        p0_resp_valid;
    logic [31:0] p0_resp_bits_data;

    logic        p1_req_valid;
    logic [31:0] p1_req_bits_addr;
    logic [31:0] p1_req_bits_data;
    logic        p1_req_bits_fcn;
    logic [2:0]  p1_req_bits_typ;
    logic        p1_resp_valid;
    logic [31:0] p1_resp_bits_data;

    logic        dbg_req_valid;
    logic [31:0] dbg_req_bits_addr;
    logic [31:0] dbg_req_bits_data;
    logic        dbg_req_bits_fcn;
    logic [2:0]  dbg_req_bits_typ;
    logic        dbg_resp_valid;
    logic [31:0] dbg_resp_bits_data;

    modport master (
        output p0_req_valid, p0_req_bits_addr, p0_req_bits_fcn, p0_req_bits_typ,
        input  p0_resp_valid, p0_resp_bits_data,
        output p1_req_valid, p1_req_bits_addr, p1_req_bits_data, p1_req_bits_fcn, p1_req_bits_typ,
        input  p1_resp_valid, p1_resp_bits_data,
        output dbg_req_valid, dbg_req_bits_addr, dbg_req_bits_data, dbg_req_bits_fcn, dbg_req_bits_typ,
        input  dbg_resp_valid, dbg_resp_bits_data
    );

    modport slave (
        input  p0_req_valid, p0_req_bits_addr, p0_req_bits_fcn, p0_req_bits_typ,
        output p0_resp_valid, p0_resp_bits_data,
        input  p1_req_valid, p1_req_bits_addr, p1_req_bits_data, p1_req_bits_fcn, p1_req_bits_typ,
        output p1_resp_valid, p1_resp_bits_data,
        input  dbg_req_valid, dbg_req_bits_addr, dbg_req_bits_data, dbg_req_bits_fcn, dbg_req_bits_typ,
        output dbg_resp_valid, dbg_resp_bits_data
    );
endinterface

// File: rtl/sodor_scratchpad_mem.sv
// Three-port scratchpad for the Sodor-2 core: typed loads/stores, fixed response latency.
// Port order inside this module: 0 = fetch, 1 = data, 2 = debug.
module sodor_scratchpad_mem #(
    parameter int ADDR_W       = 12,
    parameter int RESP_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    sodor_scratchpad_mem_if.slave mem
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NPORT = 3;

    localparam logic [2:0] TYP_B  = 3'd1;
    localparam logic [2:0] TYP_H  = 3'd2;
    localparam logic [2:0] TYP_BU = 3'd5;
    localparam logic [2:0] TYP_HU = 3'd6;

    generate
        if (RESP_LATENCY < 1 || RESP_LATENCY > 4) begin : gBadLatency
            $error("sodor_scratchpad_mem: RESP_LATENCY must be in 1..4");
        end
    endgenerate

    function automatic logic [3:0] laneMask(input logic [2:0] typ, input logic [1:0] a);
        case (typ)
            TYP_B, TYP_BU: laneMask = 4'b0001 << a;
            TYP_H, TYP_HU: laneMask = a[1] ? 4'b1100 : 4'b0011;
            default:       laneMask = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data so every lane carries the right bytes; the mask picks lanes.
    function automatic logic [31:0] storeData(input logic [2:0] typ, input logic [31:0] d);
        case (typ)
            TYP_B, TYP_BU: storeData = {4{d[7:0]}};
            TYP_H, TYP_HU: storeData = {2{d[15:0]}};
            default:       storeData = d;
        endcase
    endfunction

    function automatic logic [31:0] fmtLoad(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] typ);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (typ)
            TYP_B:   fmtLoad = {{24{b[7]}}, b};
            TYP_BU:  fmtLoad = {24'b0, b};
            TYP_H:   fmtLoad = {{16{h[15]}}, h};
            TYP_HU:  fmtLoad = {16'b0, h};
            default: fmtLoad = w;
        endcase
    endfunction

    logic [31:0]       ram [DEPTH];

    logic              reqValid [NPORT];
    logic              reqWrite [NPORT];
    logic [31:0]       reqAddr  [NPORT];
    logic [2:0]        reqTyp   [NPORT];
    logic [ADDR_W-1:0] idx      [NPORT];
    logic [31:0]       capData  [NPORT];

    assign reqValid[0] = mem.p0_req_valid;
    assign reqWrite[0] = 1'b0;
    assign reqAddr[0]  = mem.p0_req_bits_addr;
    assign reqTyp[0]   = mem.p0_req_bits_typ;
    assign reqValid[1] = mem.p1_req_valid;
    assign reqWrite[1] = mem.p1_req_bits_fcn;
    assign reqAddr[1]  = mem.p1_req_bits_addr;
    assign reqTyp[1]   = mem.p1_req_bits_typ;
    assign reqValid[2] = mem.dbg_req_valid;
    assign reqWrite[2] = mem.dbg_req_bits_fcn;
    assign reqAddr[2]  = mem.dbg_req_bits_addr;
    assign reqTyp[2]   = mem.dbg_req_bits_typ;

    // Address bits above the array index wrap; port 0 is read-only so its fcn has no effect.
    logic unusedBits;
    assign unusedBits = ^{mem.p0_req_bits_fcn, mem.p0_req_bits_addr[31:ADDR_W+2],
                          mem.p1_req_bits_addr[31:ADDR_W+2], mem.dbg_req_bits_addr[31:ADDR_W+2]};

    // Reads see pre-edge contents, so a same-cycle write to the word is not observed.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            idx[p]     = reqAddr[p][ADDR_W+1:2];
            capData[p] = '0;
            if (reqValid[p] && !reqWrite[p]) begin
                capData[p] = fmtLoad(ram[idx[p]], reqAddr[p][1:0], reqTyp[p]);
            end
        end
    end

    logic        p1Wr;
    logic        dbgWr;
    logic [3:0]  p1Mask;
    logic [3:0]  dbgMask;
    logic [31:0] p1Wd;
    logic [31:0] dbgWd;

    assign p1Wr    = mem.p1_req_valid && mem.p1_req_bits_fcn;
    assign dbgWr   = mem.dbg_req_valid && mem.dbg_req_bits_fcn;
    assign p1Mask  = laneMask(mem.p1_req_bits_typ, mem.p1_req_bits_addr[1:0]);
    assign dbgMask = laneMask(mem.dbg_req_bits_typ, mem.dbg_req_bits_addr[1:0]);
    assign p1Wd    = storeData(mem.p1_req_bits_typ, mem.p1_req_bits_data);
    assign dbgWd   = storeData(mem.dbg_req_bits_typ, mem.dbg_req_bits_data);

    // Debug lanes are written last so they win any overlap with port 1 on the same word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int l = 0; l < 4; l++) begin
                if (p1Wr && p1Mask[l]) ram[idx[1]][8*l +: 8] <= p1Wd[8*l +: 8];
            end
            for (int l = 0; l < 4; l++) begin
                if (dbgWr && dbgMask[l]) ram[idx[2]][8*l +: 8] <= dbgWd[8*l +: 8];
            end
        end
    end

    logic [RESP_LATENCY-1:0] vPipe [NPORT];
    logic [31:0]             dPipe [NPORT][RESP_LATENCY];

    always_ff @(posedge clock) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset) begin
                vPipe[p] <= '0;
                for (int i = 0; i < RESP_LATENCY; i++) dPipe[p][i] <= '0;
            end else begin
                vPipe[p][0] <= reqValid[p];
                dPipe[p][0] <= capData[p];
                for (int i = 1; i < RESP_LATENCY; i++) begin
                    vPipe[p][i] <= vPipe[p][i-1];
                    dPipe[p][i] <= dPipe[p][i-1];
                end
            end
        end
    end

    assign mem.p0_resp_valid      = vPipe[0][RESP_LATENCY-1];
    assign mem.p0_resp_bits_data  = dPipe[0][RESP_LATENCY-1];
    assign mem.p1_resp_valid      = vPipe[1][RESP_LATENCY-1];
    assign mem.p1_resp_bits_data  = dPipe[1][RESP_LATENCY-1];
    assign mem.dbg_resp_valid     = vPipe[2][RESP_LATENCY-1];
    assign mem.dbg_resp_bits_data = dPipe[2][RESP_LATENCY-1];
endmodule

// File: tb/tb_sodor_scratchpad_mem.sv
// Bench for sodor_scratchpad_mem: one instance at latency 1, one at latency 3.
// Expected responses are queued per port with their due cycle and checked on the falling edge.
module tb_sodor_scratchpad_mem;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst1;
    logic rst3;

    sodor_scratchpad_mem_if bus1();
    sodor_scratchpad_mem_if bus3();

    sodor_scratchpad_mem #(.ADDR_W(12), .RESP_LATENCY(1)) dut1 (.clock(clock), .reset(rst1), .mem(bus1));
    sodor_scratchpad_mem #(.ADDR_W(12), .RESP_LATENCY(3)) dut3 (.clock(clock), .reset(rst3), .mem(bus3));

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          fcn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
        logic [31:0] exp;
    } vec_t;

    exp_t  sbq [6][$];
    vec_t  vecs [$];
    int    lat [2] = '{1, 3};
    string pn  [3] = '{"p0", "p1", "dbg"};

    int cyc     = 0;
    int nAssert = 0;
    int nFail   = 0;
    bit monOn   = 0;
    bit chkZero = 0;

    logic        vObs [2][3];
    logic [31:0] dObs [2][3];

    always_comb begin
        vObs[0][0] = bus1.p0_resp_valid;  dObs[0][0] = bus1.p0_resp_bits_data;
        vObs[0][1] = bus1.p1_resp_valid;  dObs[0][1] = bus1.p1_resp_bits_data;
        vObs[0][2] = bus1.dbg_resp_valid; dObs[0][2] = bus1.dbg_resp_bits_data;
        vObs[1][0] = bus3.p0_resp_valid;  dObs[1][0] = bus3.p0_resp_bits_data;
        vObs[1][1] = bus3.p1_resp_valid;  dObs[1][1] = bus3.p1_resp_bits_data;
        vObs[1][2] = bus3.dbg_resp_valid; dObs[1][2] = bus3.dbg_resp_bits_data;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (monOn) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 3; p++) begin
                    nAssert++;
                    if (sbq[d*3+p].size() > 0 && sbq[d*3+p][0].due == cyc) begin
                        if (vObs[d][p] !== 1'b1 || dObs[d][p] !== sbq[d*3+p][0].data) begin
                            nFail++;
                            $display("FAIL resp dut%0d %s cyc %0d: got valid=%b data=%h, want valid=1 data=%h",
                                     lat[d], pn[p], cyc, vObs[d][p], dObs[d][p], sbq[d*3+p][0].data);
                        end
                        void'(sbq[d*3+p].pop_front());
                    end else if (vObs[d][p] !== 1'b0) begin
                        nFail++;
                        $display("FAIL idle dut%0d %s cyc %0d: got valid=%b, want valid=0",
                                 lat[d], pn[p], cyc, vObs[d][p]);
                    end
                    if (chkZero && d == 0) begin
                        nAssert++;
                        if (dObs[d][p] !== 32'h0) begin
                            nFail++;
                            $display("FAIL resetdata %s cyc %0d: got data=%h, want 00000000",
                                     pn[p], cyc, dObs[d][p]);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        bus1.p0_req_valid = 1'b0; bus1.p1_req_valid = 1'b0; bus1.dbg_req_valid = 1'b0;
        bus3.p0_req_valid = 1'b0; bus3.p1_req_valid = 1'b0; bus3.dbg_req_valid = 1'b0;
    endtask

    // Drive one request in the current cycle; when expResp is set, queue its response.
    task automatic req(input int d, input int p, input bit fcn, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] typ,
                       input logic [31:0] exp, input bit expResp);
        exp_t e;
        case (d * 3 + p)
            0: begin bus1.p0_req_valid = 1; bus1.p0_req_bits_fcn = fcn; bus1.p0_req_bits_addr = addr;
                     bus1.p0_req_bits_typ = typ; end
            1: begin bus1.p1_req_valid = 1; bus1.p1_req_bits_fcn = fcn; bus1.p1_req_bits_addr = addr;
                     bus1.p1_req_bits_data = data; bus1.p1_req_bits_typ = typ; end
            2: begin bus1.dbg_req_valid = 1; bus1.dbg_req_bits_fcn = fcn; bus1.dbg_req_bits_addr = addr;
                     bus1.dbg_req_bits_data = data; bus1.dbg_req_bits_typ = typ; end
            3: begin bus3.p0_req_valid = 1; bus3.p0_req_bits_fcn = fcn; bus3.p0_req_bits_addr = addr;
                     bus3.p0_req_bits_typ = typ; end
            4: begin bus3.p1_req_valid = 1; bus3.p1_req_bits_fcn = fcn; bus3.p1_req_bits_addr = addr;
                     bus3.p1_req_bits_data = data; bus3.p1_req_bits_typ = typ; end
            default: begin bus3.dbg_req_valid = 1; bus3.dbg_req_bits_fcn = fcn; bus3.dbg_req_bits_addr = addr;
                     bus3.dbg_req_bits_data = data; bus3.dbg_req_bits_typ = typ; end
        endcase
        if (expResp) begin
            e.due  = cyc + lat[d];
            e.data = exp;
            sbq[d*3+p].push_back(e);
        end
    endtask

    initial begin
        bus1.p0_req_valid = 0; bus1.p0_req_bits_addr = 0; bus1.p0_req_bits_fcn = 0; bus1.p0_req_bits_typ = 3;
        bus1.p1_req_valid = 0; bus1.p1_req_bits_addr = 0; bus1.p1_req_bits_data = 0;
        bus1.p1_req_bits_fcn = 0; bus1.p1_req_bits_typ = 3;
        bus1.dbg_req_valid = 0; bus1.dbg_req_bits_addr = 0; bus1.dbg_req_bits_data = 0;
        bus1.dbg_req_bits_fcn = 0; bus1.dbg_req_bits_typ = 3;
        bus3.p0_req_valid = 0; bus3.p0_req_bits_addr = 0; bus3.p0_req_bits_fcn = 0; bus3.p0_req_bits_typ = 3;
        bus3.p1_req_valid = 0; bus3.p1_req_bits_addr = 0; bus3.p1_req_bits_data = 0;
        bus3.p1_req_bits_fcn = 0; bus3.p1_req_bits_typ = 3;
        bus3.dbg_req_valid = 0; bus3.dbg_req_bits_addr = 0; bus3.dbg_req_bits_data = 0;
        bus3.dbg_req_bits_fcn = 0; bus3.dbg_req_bits_typ = 3;
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Word write/read, then byte/half formatting and narrow stores on 0x8899AABB @0x20.
        vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 3'd3, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        3'd3, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h20, 32'h8899AABB, 3'd3, 32'h0});
        vecs.push_back('{1'b0, 32'h21, 32'h0,        3'd1, 32'hFFFFFFAA});
        vecs.push_back('{1'b0, 32'h21, 32'h0,        3'd5, 32'h000000AA});
        vecs.push_back('{1'b0, 32'h22, 32'h0,        3'd2, 32'hFFFF8899});
        vecs.push_back('{1'b0, 32'h22, 32'h0,        3'd6, 32'h00008899});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd1, 32'hFFFFFFBB});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd2, 32'hFFFFAABB});
        vecs.push_back('{1'b0, 32'h23, 32'h0,        3'd2, 32'hFFFF8899});
        vecs.push_back('{1'b0, 32'h23, 32'h0,        3'd5, 32'h00000088});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd0, 32'h8899AABB});
        vecs.push_back('{1'b0, 32'h21, 32'h0,        3'd7, 32'h8899AABB});
        vecs.push_back('{1'b0, 32'h22, 32'h0,        3'd4, 32'h8899AABB});
        vecs.push_back('{1'b1, 32'h23, 32'hFFFFFF11, 3'd1, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd3, 32'h1199AABB});
        vecs.push_back('{1'b1, 32'h21, 32'h1234CAFE, 3'd6, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd3, 32'h1199CAFE});
        vecs.push_back('{1'b1, 32'h22, 32'hABCDEF77, 3'd5, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd3, 32'h1177CAFE});
        vecs.push_back('{1'b0, 32'h22, 32'h0,        3'd2, 32'h00001177});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        3'd1, 32'hFFFFFFFE});

        tick();
        tick();
        rst1 = 1'b1;
        rst3 = 1'b1;
        monOn = 1'b1;

        // Reset drops in-reset requests: the write of 0 to 0x30 must not land.
        tick(); req(0, 1, 1, 32'h30, 32'hA5A5A5A5, 3'd3, 32'h0, 1);
        tick(); rst1 = 1'b0; chkZero = 1'b1; req(0, 1, 1, 32'h30, 32'h0, 3'd3, 32'h0, 0);
        tick(); req(0, 1, 1, 32'h30, 32'h0, 3'd3, 32'h0, 0);
        tick(); rst1 = 1'b1;
        tick(); chkZero = 1'b0; req(0, 1, 0, 32'h30, 32'h0, 3'd3, 32'hA5A5A5A5, 1);

        foreach (vecs[i]) begin
            tick();
            req(0, 1, vecs[i].fcn, vecs[i].addr, vecs[i].data, vecs[i].typ, vecs[i].exp, 1);
        end

        // Same-cycle dbg/p1 writes with a p0 read of the old word, then per-lane merge.
        tick(); req(0, 1, 1, 32'h40, 32'h33333333, 3'd3, 32'h0, 1);
        tick(); req(0, 2, 1, 32'h40, 32'h11111111, 3'd3, 32'h0, 1);
                req(0, 1, 1, 32'h42, 32'h00002222, 3'd2, 32'h0, 1);
                req(0, 0, 0, 32'h40, 32'h0, 3'd3, 32'h33333333, 1);
        tick(); req(0, 0, 0, 32'h40, 32'h0, 3'd3, 32'h11111111, 1);
        tick(); req(0, 2, 1, 32'h41, 32'h00000044, 3'd1, 32'h0, 1);
                req(0, 1, 1, 32'h40, 32'h00005555, 3'd2, 32'h0, 1);
        tick(); req(0, 2, 0, 32'h40, 32'h0, 3'd3, 32'h11114455, 1);
        tick(); req(0, 0, 1, 32'h40, 32'h0, 3'd3, 32'h11114455, 1);

        // Upper address bits wrap onto the same word.
        tick(); req(0, 1, 1, 32'h4000, 32'h0BADF00D, 3'd3, 32'h0, 1);
        tick(); req(0, 0, 0, 32'h0, 32'h0, 3'd3, 32'h0BADF00D, 1);

        // Latency-3 instance: preload, back-to-back burst, then reset mid-burst.
        for (int i = 0; i < 4; i++) begin
            tick(); req(1, 1, 1, 32'h100 + 4*i, 32'hC0DE0000 + i, 3'd3, 32'h0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); req(1, 0, 0, 32'h100 + 4*i, 32'h0, 3'd3, 32'hC0DE0000 + i, 1);
        end
        repeat (4) tick();
        tick(); req(1, 0, 0, 32'h100, 32'h0, 3'd3, 32'hC0DE0000, 1);
        tick(); req(1, 0, 0, 32'h104, 32'h0, 3'd3, 32'hC0DE0001, 1);
        tick(); rst3 = 1'b0; sbq[3].delete(); req(1, 0, 0, 32'h108, 32'h0, 3'd3, 32'h0, 0);
        tick(); rst3 = 1'b1; req(1, 0, 0, 32'h10C, 32'h0, 3'd3, 32'hC0DE0003, 1);

        repeat (6) tick();
        for (int k = 0; k < 6; k++) begin
            nAssert++;
            if (sbq[k].size() != 0) begin
                nFail++;
                $display("FAIL drain queue %0d: got %0d pending responses, want 0", k, sbq[k].size());
            end
        end
        monOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
